or_bus_arbiter: RTL and testbench

//  Shares one OR-combined output bus among N packet requesters, using round-robin arbitration.
//  The grant is locked for a whole packet: it holds from grant until the beat with last=1 is accepted.
//  The output bus is an AND-OR combine (one-hot grant masks each requester, then all are ORed), so
//  the grant must be strictly one-hot or zero. Sits between producer blocks and one shared sink port.
//  The output is a registered 1-entry stage with valid/ready on both sides.

---
 rtl/arb_pkg.sv | 12 +
 rtl/or_bus_arbiter_rr_pick.sv | 26 ++
 rtl/or_bus_arbiter.sv | 114 +++++++++++
 tb/tb_or_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the OR-bus arbiter: FSM state encoding and default sizes.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

endpackage

// File: rtl/or_bus_arbiter_rr_pick.sv
// Rotating-priority first-one search: returns the first set request at or after ptr, modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    // Offsets are reduced mod N, so indices >= N (non-power-of-2 N) are never produced.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = SW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/or_bus_arbiter.sv
// Round-robin, packet-locked arbiter driving one AND-OR combined bus through a
// registered 1-entry output stage. busy mirrors the FSM state (1 in LOCK).
module or_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [SW-1:0]  out_src,
    input  logic           out_ready,
    output logic           busy
);

    // Handshake: a beat moves on a side when valid & ready are both 1 at the rising edge;
    // valid never waits on ready, and ready may depend combinationally on the sink side.

    state_e        state, state_d;
    logic [SW-1:0] ptr, ptr_d;
    logic [SW-1:0] gnt_idx, gnt_idx_d;
    logic [N-1:0]  gnt;
    logic          stage_free;
    logic          accept;
    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic [W-1:0]  comb_data;

    rr_pick #(.N(N)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant is one-hot only while locked, so the AND-OR bus never mixes sources.
    always_comb begin
        gnt = '0;
        if (state == ST_LOCK) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign stage_free = ~out_valid | out_ready;
    assign req_ready  = gnt & {N{stage_free}};
    assign accept     = |(req_valid & req_ready);
    assign busy       = (state == ST_LOCK);

    always_comb begin
        comb_data = '0;
        for (int i = 0; i < N; i++) begin
            comb_data = comb_data | (req_data[i*W +: W] & {W{gnt[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            gnt_idx <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        gnt_idx_d = gnt_idx;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_idx_d = pick_idx;
                    state_d   = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && req_last[gnt_idx]) begin
                    state_d = ST_IDLE;
                    ptr_d   = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage: a load wins over a drain, giving gap-free streaming inside a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= comb_data;
            out_last  <= req_last[gnt_idx];
            out_src   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_or_bus_arbiter.sv
// Scoreboard bench for or_bus_arbiter: per-requester packet queues feed the DUT,
// accepted beats are queued as expectations and matched against the output stage.
module tb_or_bus_arbiter;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;
    localparam int EW = SW + 1 + W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           out_ready = 1'b1;
    logic           busy;

    logic [W-1:0]  src_data[N][$];
    logic          src_last[N][$];
    logic [EW-1:0] exp_q[$];
    logic [SW-1:0] log_src[$];
    logic [W-1:0]  log_data[$];
    int            log_cyc[$];
    logic [W-1:0]  last_sent[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    or_bus_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit all_src_empty();
        for (int i = 0; i < N; i++) begin
            if (src_data[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            src_data[i].delete();
            src_last[i].delete();
        end
        exp_q.delete();
    endtask

    task automatic clear_log();
        log_src.delete();
        log_data.delete();
        log_cyc.delete();
        last_sent.delete();
    endtask

    task automatic send_pkt(input int r, input int len);
        logic [W-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = W'($urandom_range(0, 255));
            src_data[r].push_back(d);
            src_last[r].push_back(b == len - 1);
            last_sent.push_back(d);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            #2;
            done = all_src_empty() && exp_q.size() == 0 && !out_valid;
            n++;
            if (!done && n >= budget) begin
                check(tag, 32'd0, 32'd1);
                done = 1'b1;
            end
        end
    endtask

    task automatic wait_src_size(input string tag, input int r, input int sz, input int budget);
        int n;
        n = 0;
        while (src_data[r].size() != sz && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (src_data[r].size() != sz) check(tag, 32'(src_data[r].size()), 32'(sz));
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_queues();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        clear_log();
    endtask

    // Driver + monitor: outputs checked and accepts recorded on the falling edge,
    // requester inputs updated 1 time unit after the rising edge.
    initial begin
        logic [N-1:0]  acc;
        logic [EW-1:0] e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_beat", 32'({out_src, out_last, out_data}), 32'(e));
                end
                log_src.push_back(out_src);
                log_data.push_back(out_data);
                log_cyc.push_back(cyc);
            end
            if (rst_n) check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            acc = rst_n ? (req_valid & req_ready) : '0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) exp_q.push_back({SW'(i), req_last[i], req_data[i*W +: W]});
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_data[i].size() > 0) begin
                    void'(src_data[i].pop_front());
                    void'(src_last[i].pop_front());
                end
                req_valid[i] = (src_data[i].size() > 0);
                req_data[i*W +: W] = (src_data[i].size() > 0) ? src_data[i][0] : '0;
                req_last[i] = (src_data[i].size() > 0) ? src_last[i][0] : 1'b0;
            end
        end
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [W-1:0] a[3];
        logic [W-1:0] b;
        logic [W-1:0] p[5];

        // Reset held while requests are present.
        send_pkt(0, 1);
        send_pkt(2, 1);
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        src_data[2].delete();
        src_last[2].delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_drain("t1_drain_timeout", 50);
        check("t1_beats", 32'(log_src.size()), 32'd1);
        if (log_src.size() > 0) check("t1_first_src", 32'(log_src[0]), 32'd0);

        // Round robin across all requesters with 1-beat packets.
        apply_reset();
        out_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++) send_pkt(r, 1);
        wait_drain("t2_drain_timeout", 200);
        check("t2_beats", 32'(log_src.size()), 32'd8);
        if (log_src.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("t2_rr_src", 32'(log_src[k]), 32'(k % N));
            for (int k = 1; k < 5; k++) check("t2_rr_gap", 32'(log_cyc[k] - log_cyc[k-1]), 32'd2);
        end

        // Packet lock: req1 arrives mid-packet and must wait for req0's last beat.
        apply_reset();
        send_pkt(0, 3);
        for (int k = 0; k < 3; k++) a[k] = last_sent[k];
        wait_src_size("t3_wait_a1", 0, 2, 50);
        send_pkt(1, 1);
        b = last_sent[3];
        for (int n = 0; n < 50 && src_data[0].size() > 0; n++) begin
            @(negedge clk);
            check("t3_lock_ready1", 32'(req_ready[1]), 32'd0);
        end
        wait_drain("t3_drain_timeout", 100);
        check("t3_beats", 32'(log_src.size()), 32'd4);
        if (log_src.size() == 4) begin
            for (int k = 0; k < 3; k++) check("t3_a_data", 32'(log_data[k]), 32'(a[k]));
            check("t3_a_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
            check("t3_a_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd1);
            check("t3_b_src", 32'(log_src[3]), 32'd1);
            check("t3_b_data", 32'(log_data[3]), 32'(b));
        end

        // Backpressure for 5 cycles mid-packet.
        apply_reset();
        send_pkt(0, 5);
        for (int k = 0; k < 5; k++) p[k] = last_sent[k];
        wait_src_size("t4_wait_two", 0, 3, 50);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", 32'(out_data), 32'(p[1]));
            check("t4_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain("t4_drain_timeout", 100);
        check("t4_beats", 32'(log_data.size()), 32'd5);
        if (log_data.size() == 5)
            for (int k = 0; k < 5; k++) check("t4_data", 32'(log_data[k]), 32'(p[k]));

        // Pointer wrap and skip: ptr=3 with requesters 0 and 2 pending.
        apply_reset();
        send_pkt(2, 1);
        wait_drain("t5_drain_a_timeout", 50);
        send_pkt(0, 1);
        send_pkt(2, 1);
        wait_drain("t5_drain_b_timeout", 50);
        check("t5_beats", 32'(log_src.size()), 32'd3);
        if (log_src.size() == 3) begin
            check("t5_src0", 32'(log_src[0]), 32'd2);
            check("t5_src1", 32'(log_src[1]), 32'd0);
            check("t5_src2", 32'(log_src[2]), 32'd2);
        end

        // Async reset in the middle of a packet, between clock edges.
        apply_reset();
        send_pkt(2, 1);
        wait_drain("t6_drain_a_timeout", 50);
        send_pkt(1, 4);
        wait_src_size("t6_wait_two", 1, 2, 50);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd0);
        clear_queues();
        clear_log();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        send_pkt(3, 1);
        send_pkt(0, 1);
        wait_drain("t6_drain_b_timeout", 50);
        check("t6_beats", 32'(log_src.size()), 32'd2);
        if (log_src.size() == 2) begin
            check("t6_first_src", 32'(log_src[0]), 32'd0);
            check("t6_second_src", 32'(log_src[1]), 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
